buzzer_sequencer: RTL and testbench

Note-sequencing controller for the buzzer tone generator. It holds a 16-entry note table of frequency/duration pairs. On start it plays the entries in order, driving the tone generator's frequency and enable inputs. Each note is followed by a fixed silent gap, and the sequence ends on an end-of-song marker or the last entry, with optional looping.

---
 rtl/buzzer_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_buzzer_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_sequencer.sv
// Note-sequencing controller for the buzzer tone generator.
// Plays a 16-entry table of frequency/duration pairs. Each note is followed by
// a fixed silent gap. The song ends on a zero-duration entry or after entry 15,
// and can optionally loop back to entry 0.
module buzzer_sequencer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int GAP_TICKS = 20,
  parameter int IDLE_FREQ = 440
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_loop,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_addr,
  input  logic [15:0] i_wr_freq,
  input  logic [11:0] i_wr_dur,
  output logic [15:0] o_freq,
  output logic        o_en,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_note_idx
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int PRESC_W  = $clog2(TICK_CYC);
  localparam int GAP_W    = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);

  localparam logic [15:0]        IDLE_FREQ_V = 16'(IDLE_FREQ);
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICK_CYC - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD    = GAP_W'(GAP_TICKS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [15:0]        freq_tbl_q [16];
  logic [11:0]        dur_tbl_q  [16];

  logic [1:0]         state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [11:0]        dur_q, dur_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [15:0]        freq_q, freq_d;
  logic               en_q, en_d;
  logic               done_q, done_d;

  logic [15:0]        rd_freq;
  logic [11:0]        rd_dur;
  logic               tick;
  logic               advance;
  logic               end_song;

  // A write and a LOAD of the same entry in one cycle see the old contents,
  // because the table is only updated at the clock edge.
  assign rd_freq = freq_tbl_q[idx_q];
  assign rd_dur  = dur_tbl_q[idx_q];
  assign tick    = (presc_q == PRESC_LAST);

  // Note table: registered writes, accepted in any state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: the table must come out of reset as all end-of-song markers, so it
      // is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) begin
        freq_tbl_q[i] <= '0;
        dur_tbl_q[i]  <= '0;
      end
    end else if (i_wr_en) begin
      freq_tbl_q[i_wr_addr] <= i_wr_freq;
      dur_tbl_q[i_wr_addr]  <= i_wr_dur;
    end
  end

  // Next-state logic: sequencing, tick prescaler, duration and gap counters.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    dur_d    = dur_q;
    gap_d    = gap_q;
    presc_d  = presc_q;
    freq_d   = freq_q;
    en_d     = en_q;
    done_d   = 1'b0;
    advance  = 1'b0;
    end_song = 1'b0;

    // The prescaler only runs while a note or gap is being timed.
    if (state_q == S_PLAY || state_q == S_GAP) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (rd_dur == 12'd0) begin
          end_song = 1'b1;
        end else begin
          // A rest keeps the divider fed with a nonzero frequency.
          freq_d  = (rd_freq == 16'd0) ? IDLE_FREQ_V : rd_freq;
          en_d    = (rd_freq != 16'd0);
          dur_d   = rd_dur;
          presc_d = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          dur_d = dur_q - 12'd1;
          if (dur_q == 12'd1) begin
            en_d   = 1'b0;
            freq_d = IDLE_FREQ_V;
            if (GAP_TICKS == 0) begin
              advance = 1'b1;
            end else begin
              gap_d   = GAP_LOAD;
              presc_d = '0;
              state_d = S_GAP;
            end
          end
        end
      end
      default: begin // S_GAP
        if (tick) begin
          gap_d = gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) begin
            advance = 1'b1;
          end
        end
      end
    endcase

    // Advance is a transition, not a state: index 15 is checked before the
    // increment so the index never wraps on its own.
    if (advance) begin
      if (idx_q == 4'd15) begin
        end_song = 1'b1;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = S_LOAD;
      end
    end

    // End of song is also a transition: loop back or finish with a done pulse.
    if (end_song) begin
      idx_d = '0;
      if (i_loop) begin
        state_d = S_LOAD;
      end else begin
        done_d  = 1'b1;
        presc_d = '0;
        state_d = S_IDLE;
      end
    end

    // Abort wins over start, tick and end-of-song alike.
    if (i_stop) begin
      state_d = S_IDLE;
      idx_d   = '0;
      dur_d   = '0;
      gap_d   = '0;
      presc_d = '0;
      freq_d  = IDLE_FREQ_V;
      en_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
      presc_q <= '0;
      freq_q  <= IDLE_FREQ_V;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge.
      state_q <= state_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      presc_q <= presc_d;
      freq_q  <= freq_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign o_freq     = freq_q;
  assign o_en       = en_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = done_q;
  assign o_note_idx = idx_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Testbench for buzzer_sequencer: expected output runs (enable, frequency,
// length in cycles) are queued per song and compared as the DUT plays it.
module tb_buzzer_sequencer;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int GAP_TICKS = 2;
  localparam int IDLE_FREQ = 440;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop_en, wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_freq;
  logic [11:0] wr_dur;
  logic [15:0] o_freq;
  logic        o_en, o_busy, o_done;
  logic [3:0]  o_note_idx;

  always #5 clk = ~clk;

  buzzer_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .GAP_TICKS(GAP_TICKS), .IDLE_FREQ(IDLE_FREQ)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_loop(loop_en),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_freq(wr_freq), .i_wr_dur(wr_dur),
    .o_freq(o_freq), .o_en(o_en), .o_busy(o_busy), .o_done(o_done),
    .o_note_idx(o_note_idx)
  );

  typedef struct {
    bit is_end;
    bit en;
    int freq;
    int len;
    bit done;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    done_cnt = 0;
  string cur_test = "reset";

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d expected %0d", cur_test, tag, act, exp);
    end
  endtask

  task automatic push_run(input bit en, input int freq, input int len);
    exp_t e;
    e.is_end = 1'b0; e.en = en; e.freq = freq; e.len = len; e.done = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_end(input bit done);
    exp_t e;
    e.is_end = 1'b1; e.en = 1'b0; e.freq = IDLE_FREQ; e.len = 0; e.done = done;
    sb.push_back(e);
  endtask

  // Output monitor: collapses busy-time outputs into runs of equal (en, freq).
  bit prev_busy = 1'b0;
  bit prev_done = 1'b0;
  bit run_en;
  int run_freq;
  int run_len;

  task automatic emit_run();
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_run", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("run_kind", 32'd0, 32'(e.is_end));
      check("run_en", 32'(run_en), 32'(e.en));
      check("run_freq", 32'(run_freq), 32'(e.freq));
      check("run_len", 32'(run_len), 32'(e.len));
    end
  endtask

  task automatic emit_end();
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_end", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("end_kind", 32'd1, 32'(e.is_end));
      check("end_done", 32'(o_done), 32'(e.done));
      check("idle_en", 32'(o_en), 32'd0);
      check("idle_freq", 32'(o_freq), 32'(IDLE_FREQ));
      check("idle_idx", 32'(o_note_idx), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (prev_done) check("done_width", 32'(o_done), 32'd0);
    if (o_done === 1'b1) done_cnt++;
    if (o_busy === 1'b1) begin
      if (prev_busy && o_en == run_en && int'(o_freq) == run_freq) begin
        run_len++;
      end else begin
        if (prev_busy) emit_run();
        run_en   = o_en;
        run_freq = int'(o_freq);
        run_len  = 1;
      end
    end else if (prev_busy) begin
      emit_run();
      emit_end();
    end
    prev_busy = (o_busy === 1'b1);
    prev_done = (o_done === 1'b1);
  end

  // Stimulus helpers; inputs change only on the falling edge.
  task automatic write_note(input int addr, input int freq, input int dur);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_freq = 16'(freq); wr_dur = 12'(dur);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sound(input int freq, input int budget);
    int n = 0;
    while (!(o_en === 1'b1 && int'(o_freq) == freq) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("timeout_sound", 32'd0, 32'd1);
  endtask

  task automatic wait_idx(input int idx, input int budget);
    int n = 0;
    while (int'(o_note_idx) != idx && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("timeout_idx", 32'd0, 32'd1);
  endtask

  task automatic finish_test(input int base, input int exp_done);
    int n = 0;
    while (o_busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      check("timeout_idle", 32'd0, 32'd1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(sb.size()), 32'd0);
    check("done_count", 32'(done_cnt - base), 32'(exp_done));
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_freq", 32'(o_freq), 32'(IDLE_FREQ));
    check("rst_en", 32'(o_en), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_idx", 32'(o_note_idx), 32'd0);

    // Empty table: one LOAD cycle, then done.
    cur_test = "empty";
    base = done_cnt;
    push_run(1'b0, IDLE_FREQ, 1);
    push_end(1'b1);
    pulse_start();
    finish_test(base, 1);

    // Two notes then an end marker.
    cur_test = "basic";
    write_note(0, 262, 3);
    write_note(1, 330, 2);
    write_note(2, 0, 0);
    base = done_cnt;
    push_run(1'b0, IDLE_FREQ, 1);
    push_run(1'b1, 262, 30);
    push_run(1'b0, IDLE_FREQ, 21);
    push_run(1'b1, 330, 20);
    push_run(1'b0, IDLE_FREQ, 21);
    push_end(1'b1);
    pulse_start();
    wait_sound(330, 200);
    check("basic_idx1", 32'(o_note_idx), 32'd1);
    finish_test(base, 1);

    // Rest entry stays silent at IDLE_FREQ, then a real note.
    cur_test = "rest";
    write_note(0, 0, 2);
    write_note(1, 440, 1);
    write_note(2, 0, 0);
    base = done_cnt;
    push_run(1'b0, IDLE_FREQ, 42);
    push_run(1'b1, 440, 10);
    push_run(1'b0, IDLE_FREQ, 21);
    push_end(1'b1);
    pulse_start();
    finish_test(base, 1);

    // Abort mid-note together with a start that must be ignored.
    cur_test = "stop";
    write_note(0, 262, 3);
    write_note(1, 330, 2);
    write_note(2, 0, 0);
    base = done_cnt;
    push_run(1'b0, IDLE_FREQ, 1);
    push_run(1'b1, 262, 30);
    push_run(1'b0, IDLE_FREQ, 21);
    push_run(1'b1, 330, 5);
    push_end(1'b0);
    pulse_start();
    wait_sound(330, 200);
    repeat (4) @(negedge clk);
    stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    check("stop_en", 32'(o_en), 32'd0);
    check("stop_busy", 32'(o_busy), 32'd0);
    repeat (5) @(negedge clk);
    check("stop_no_restart", 32'(o_busy), 32'd0);
    finish_test(base, 0);

    // Rewrite of the playing entry only affects the next loop pass.
    cur_test = "rewrite";
    write_note(0, 262, 3);
    write_note(1, 330, 1);
    write_note(2, 0, 0);
    loop_en = 1'b1;
    base = done_cnt;
    push_run(1'b0, IDLE_FREQ, 1);
    push_run(1'b1, 262, 30);
    push_run(1'b0, IDLE_FREQ, 21);
    push_run(1'b1, 330, 10);
    push_run(1'b0, IDLE_FREQ, 22);
    push_run(1'b1, 523, 50);
    push_run(1'b0, IDLE_FREQ, 21);
    push_run(1'b1, 330, 10);
    push_run(1'b0, IDLE_FREQ, 21);
    push_end(1'b1);
    pulse_start();
    wait_sound(262, 50);
    write_note(0, 523, 5);
    wait_sound(523, 300);
    loop_en = 1'b0;
    finish_test(base, 1);

    // Full 16-entry table, looping once, then stopping after entry 15.
    cur_test = "loop16";
    for (int i = 0; i < 16; i++) write_note(i, 100 + i, 1);
    loop_en = 1'b1;
    base = done_cnt;
    push_run(1'b0, IDLE_FREQ, 1);
    for (int i = 0; i < 16; i++) begin
      push_run(1'b1, 100 + i, 10);
      push_run(1'b0, IDLE_FREQ, 21);
    end
    for (int i = 0; i < 16; i++) begin
      push_run(1'b1, 100 + i, 10);
      push_run(1'b0, IDLE_FREQ, (i == 15) ? 20 : 21);
    end
    push_end(1'b1);
    pulse_start();
    wait_idx(15, 1000);
    wait_idx(0, 200);
    check("loop_wrap_busy", 32'(o_busy), 32'd1);
    check("loop_wrap_no_done", 32'(done_cnt - base), 32'd0);
    wait_idx(5, 400);
    loop_en = 1'b0;
    finish_test(base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
